// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the ID stage and the RAW hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 32
);
    logic                   i_id_valid;
    logic                   i_flush;
    logic                   i_rs1_en;
    logic [REG_ADDR_W-1:0]  i_rs1_addr;
    logic                   i_rs2_en;
    logic [REG_ADDR_W-1:0]  i_rs2_addr;
    logic                   i_rd_wren;
    logic [REG_ADDR_W-1:0]  i_rd_addr;
    logic                   i_is_load;
    logic                   o_stall;
    logic                   o_stall_load;
    logic [STALL_CNT_W-1:0] o_stall_cnt;

    modport master (
        output i_id_valid, i_flush, i_rs1_en, i_rs1_addr, i_rs2_en, i_rs2_addr,
               i_rd_wren, i_rd_addr, i_is_load,
        input  o_stall, o_stall_load, o_stall_cnt
    );

    modport slave (
        input  i_id_valid, i_flush, i_rs1_en, i_rs1_addr, i_rs2_en, i_rs2_addr,
               i_rd_wren, i_rd_addr, i_is_load,
        output o_stall, o_stall_load, o_stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// RAW hazard tracker beside decode: per-register write-latency countdowns,
// ID stall generation with load attribution, and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int DEPTH       = 3,
    parameter int LOAD_EXTRA  = 1,
    parameter int STALL_CNT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    hazard_scoreboard_if.slave id_bus
);
    localparam int NREG = 2 ** REG_ADDR_W;
    localparam int CW   = $clog2(DEPTH + LOAD_EXTRA + 1);
    localparam logic [CW-1:0] ALU_LAT  = CW'(DEPTH);
    localparam logic [CW-1:0] LOAD_LAT = CW'(DEPTH + LOAD_EXTRA);

    logic [CW-1:0]          cnt [NREG];
    logic [NREG-1:0]        ld;
    logic                   hz1;
    logic                   hz2;
    logic                   stall;
    logic                   stall_load;
    logic                   issue;
    logic [CW-1:0]          issue_lat;
    logic [STALL_CNT_W-1:0] stall_cnt;

    // Entry 0 is never loaded, but the explicit address checks keep x0 idle
    // regardless of what sits in cnt[0].
    always_comb begin
        hz1        = id_bus.i_rs1_en && (id_bus.i_rs1_addr != '0)
                     && (cnt[id_bus.i_rs1_addr] != '0);
        hz2        = id_bus.i_rs2_en && (id_bus.i_rs2_addr != '0)
                     && (cnt[id_bus.i_rs2_addr] != '0);
        stall      = id_bus.i_id_valid && !id_bus.i_flush && (hz1 || hz2);
        stall_load = stall && ((hz1 && ld[id_bus.i_rs1_addr])
                            || (hz2 && ld[id_bus.i_rs2_addr]));
        issue      = id_bus.i_id_valid && !id_bus.i_flush && !stall
                     && id_bus.i_rd_wren && (id_bus.i_rd_addr != '0);
        issue_lat  = id_bus.i_is_load ? LOAD_LAT : ALU_LAT;
    end

    assign id_bus.o_stall      = stall;
    assign id_bus.o_stall_load = stall_load;
    assign id_bus.o_stall_cnt  = stall_cnt;

    // A fresh issue wins over the decrement, so a WAW reload restarts the count.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            ld <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (issue && (id_bus.i_rd_addr == REG_ADDR_W'(r))) begin
                    cnt[r] <= issue_lat;
                    ld[r]  <= id_bus.i_is_load;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                    if (cnt[r] == CW'(1)) begin
                        ld[r] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed checks of the hazard scoreboard: a default instance plus a 4-bit
// stall-counter instance fed the same decode stream to exercise saturation.
module tb_hazard_scoreboard;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   exp_sc;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(32)) bus ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .STALL_CNT_W(4))  bus4 ();

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .LOAD_EXTRA(1), .STALL_CNT_W(32)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .id_bus (bus.slave)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .DEPTH(3), .LOAD_EXTRA(1), .STALL_CNT_W(4)) dut4 (
        .i_clk  (clk),
        .i_reset(rst),
        .id_bus (bus4.slave)
    );

    assign bus4.i_id_valid = bus.i_id_valid;
    assign bus4.i_flush    = bus.i_flush;
    assign bus4.i_rs1_en   = bus.i_rs1_en;
    assign bus4.i_rs1_addr = bus.i_rs1_addr;
    assign bus4.i_rs2_en   = bus.i_rs2_en;
    assign bus4.i_rs2_addr = bus.i_rs2_addr;
    assign bus4.i_rd_wren  = bus.i_rd_wren;
    assign bus4.i_rd_addr  = bus.i_rd_addr;
    assign bus4.i_is_load  = bus.i_is_load;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic f,
                          input logic r1e, input logic [4:0] r1,
                          input logic r2e, input logic [4:0] r2,
                          input logic we, input logic [4:0] rd, input logic ldi);
        bus.i_id_valid = v;
        bus.i_flush    = f;
        bus.i_rs1_en   = r1e;
        bus.i_rs1_addr = r1;
        bus.i_rs2_en   = r2e;
        bus.i_rs2_addr = r2;
        bus.i_rd_wren  = we;
        bus.i_rd_addr  = rd;
        bus.i_is_load  = ldi;
    endtask

    // One decode cycle: sample the combinational outputs mid-cycle, then clock.
    task automatic step(input logic es, input logic el, input string tag);
        @(negedge clk);
        check({tag, "_stall"}, 32'(bus.o_stall), 32'(es));
        check({tag, "_stall_load"}, 32'(bus.o_stall_load), 32'(el));
        @(posedge clk);
        if (es) exp_sc++;
        #1;
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) step(0, 0, "idle");
    endtask

    task automatic check_sc(input string tag);
        check({tag, "_cnt32"}, bus.o_stall_cnt, 32'(exp_sc));
        check({tag, "_cnt4"}, 32'(bus4.o_stall_cnt), (exp_sc > 15) ? 32'd15 : 32'(exp_sc));
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        exp_sc = 0;
        rst    = 1'b1;
        set_id(1, 0, 1, 5, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_stall", 32'(bus.o_stall), 32'd0);
        check_sc("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // ALU RAW: add x5, then sub reading x5
        set_id(1, 0, 0, 0, 0, 0, 1, 5, 0);
        step(0, 0, "alu_issue");
        set_id(1, 0, 1, 5, 0, 0, 1, 8, 0);
        repeat (3) step(1, 0, "alu_raw");
        step(0, 0, "alu_go");
        check_sc("alu_raw");
        idle(5);

        // Load-use on rs2
        set_id(1, 0, 0, 0, 0, 0, 1, 7, 1);
        step(0, 0, "lw_issue");
        set_id(1, 0, 1, 1, 1, 7, 1, 9, 0);
        repeat (4) step(1, 1, "load_use");
        step(0, 0, "load_go");
        check_sc("load_use");
        idle(6);

        // Distance 2 reader, and x0 never tracked
        set_id(1, 0, 0, 0, 0, 0, 1, 6, 0);
        step(0, 0, "dist_wr");
        set_id(1, 0, 1, 1, 0, 0, 1, 10, 0);
        step(0, 0, "dist_unrel");
        set_id(1, 0, 1, 6, 0, 0, 0, 0, 0);
        repeat (2) step(1, 0, "dist_rd");
        step(0, 0, "dist_go");
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 0, "x0_wr");
        set_id(1, 0, 1, 0, 1, 0, 1, 16, 0);
        step(0, 0, "x0_rd");
        check_sc("dist");
        idle(5);

        // WAW: lw x3, two fillers, add x3 reloads to 3 with ld cleared
        set_id(1, 0, 0, 0, 0, 0, 1, 3, 1);
        step(0, 0, "waw_lw");
        set_id(1, 0, 1, 1, 0, 0, 1, 11, 0);
        step(0, 0, "waw_f1");
        set_id(1, 0, 1, 2, 0, 0, 1, 12, 0);
        step(0, 0, "waw_f2");
        set_id(1, 0, 0, 0, 0, 0, 1, 3, 0);
        step(0, 0, "waw_add");
        set_id(1, 0, 0, 0, 1, 3, 0, 0, 0);
        repeat (3) step(1, 0, "waw_rd");
        step(0, 0, "waw_go");
        check_sc("waw");
        idle(5);

        // Flush and invalid ID: no stall, no issue, counters keep running
        set_id(1, 0, 0, 0, 0, 0, 1, 14, 0);
        step(0, 0, "fl_wr");
        set_id(1, 1, 1, 14, 0, 0, 1, 15, 1);
        step(0, 0, "fl_flush");
        set_id(1, 0, 1, 15, 0, 0, 0, 0, 0);
        step(0, 0, "fl_noissue");
        set_id(0, 0, 1, 14, 1, 14, 1, 17, 0);
        step(0, 0, "fl_invalid");
        set_id(1, 0, 1, 14, 0, 0, 0, 0, 0);
        step(0, 0, "fl_drained");
        set_id(1, 0, 1, 17, 0, 0, 0, 0, 0);
        step(0, 0, "inv_noissue");
        check_sc("flush");
        idle(4);

        // Same register read and written: pre-edge counter decides the stall
        set_id(1, 0, 0, 0, 0, 0, 1, 13, 0);
        step(0, 0, "rw_wr");
        set_id(1, 0, 1, 13, 0, 0, 1, 13, 0);
        repeat (3) step(1, 0, "rw_self");
        step(0, 0, "rw_go");
        set_id(1, 0, 1, 13, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, "rw_next");
        step(0, 0, "rw_next_go");
        check_sc("rw");
        idle(4);

        // Two more load-use pairs push the 4-bit counter well past saturation
        for (int k = 0; k < 2; k++) begin
            set_id(1, 0, 0, 0, 0, 0, 1, 20, 1);
            step(0, 0, "sat_lw");
            set_id(1, 0, 1, 20, 0, 0, 0, 0, 0);
            repeat (4) step(1, 1, "sat_use");
            step(0, 0, "sat_go");
            idle(5);
        end
        check_sc("sat");

        // Asynchronous reset in the middle of a load-use stall
        set_id(1, 0, 0, 0, 0, 0, 1, 5, 1);
        step(0, 0, "rst_lw");
        set_id(1, 0, 1, 5, 0, 0, 1, 9, 0);
        @(negedge clk);
        check("rst_pre_stall", 32'(bus.o_stall), 32'd1);
        check("rst_pre_load", 32'(bus.o_stall_load), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        exp_sc = 0;
        check("rst_mid_stall", 32'(bus.o_stall), 32'd0);
        check("rst_mid_load", 32'(bus.o_stall_load), 32'd0);
        check_sc("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, "rst_first");
        set_id(1, 0, 1, 9, 0, 0, 0, 0, 0);
        repeat (3) step(1, 0, "rst_rd9");
        step(0, 0, "rst_rd9_go");
        check_sc("rst_after");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised read-after-write hazard tracker for the non-forwarding pipeline, sitting beside decode (ID). It tracks every architectural register with an in-flight write using a per-register countdown. It stalls ID while any enabled source operand is still pending, and applies extra latency to load destinations. It also keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- `REG_ADDR_W`, default 5: register address width; `2**REG_ADDR_W` registers tracked, register 0 never tracked.
- `DEPTH`, default 3: cycles from an ALU-type issue until its result is readable from the register file.
- `LOAD_EXTRA`, default 1: additional cycles added for loads; 0 allowed.
- `STALL_CNT_W`, default 32: width of the stall performance counter.

Ports:
- `i_clk`, input, 1: clock, rising edge.
- `i_reset`, input, 1: asynchronous reset, active-high.
- `i_id_valid`, input, 1: ID holds a valid instruction.
- `i_flush`, input, 1: the ID instruction is killed this cycle.
- `i_rs1_en`, input, 1: rs1 is read.
- `i_rs1_addr`, input, `REG_ADDR_W`: rs1 address.
- `i_rs2_en`, input, 1: rs2 is read.
- `i_rs2_addr`, input, `REG_ADDR_W`: rs2 address.
- `i_rd_wren`, input, 1: the instruction writes rd.
- `i_rd_addr`, input, `REG_ADDR_W`: rd address.
- `i_is_load`, input, 1: the instruction is a load.
- `o_stall`, output, 1: hold IF/ID and inject a bubble into EX.
- `o_stall_load`, output, 1: `o_stall` is caused by at least one pending load destination.
- `o_stall_cnt`, output, `STALL_CNT_W`: number of cycles with `o_stall` high, saturating.

## Operation

State:
- Per register r (1 to 2^`REG_ADDR_W`-1):
  - countdown `cnt[r]`, width `$clog2(DEPTH+LOAD_EXTRA+1)`;
  - load flag `ld[r]`.
- Register 0 always reads as idle.

Hazard detection (combinational):
- `hz1 = i_rs1_en && i_rs1_addr!=0 && cnt[i_rs1_addr]!=0`; `hz2` is the same for rs2.
- `o_stall = i_id_valid && !i_flush && (hz1 || hz2)`.
- `o_stall_load = o_stall && ((hz1 && ld[i_rs1_addr]) || (hz2 && ld[i_rs2_addr]))`.

Issue:
- `issue = i_id_valid && !i_flush && !o_stall && i_rd_wren && i_rd_addr!=0`.
- On `issue`, at the clock edge: `cnt[rd] <= DEPTH + (i_is_load ? LOAD_EXTRA : 0)` and `ld[rd] <= i_is_load`.

Countdown:
- Every other register with `cnt!=0` decrements by 1 each edge.
- `ld[r]` clears on the edge where `cnt[r]` goes 1→0.

Boundary rules:
- **Issue to a register that is still counting (WAW):** the new load value overrides the decrement.
- **Instruction that reads and writes the same rd:** uses the pre-edge counter for the hazard check.
- **Flush:** suppresses both stall and issue for that cycle. Existing counters keep counting (conservative behaviour).
- **`i_id_valid`=0:** no stall and no issue. Counters keep running.
- **Stall counter:** `o_stall_cnt` increments on each edge where `o_stall`=1 and holds at all-ones.

## Timing

- `o_stall` and `o_stall_load` are combinational from current state and ID inputs, in the same cycle.
- **Issue-to-use stall:**
  - A writer issues in cycle t; a dependent instruction is in ID from t+1.
  - The counter reads D at t+1 and 0 at t+D+1.
  - The dependent therefore stalls exactly D cycles (D = `DEPTH`, or `DEPTH+LOAD_EXTRA` for a load).
  - It issues at t+D+1.
- **Dependent arriving k cycles after issue:** stalls max(0, D-k+1) cycles.
- **Reset (asynchronous, any time, including mid-stall):**
  - all `cnt`, all `ld`, and `o_stall_cnt` go to 0;
  - `o_stall` and `o_stall_load` go to 0 immediately;
  - the first valid ID instruction after reset deasserts is never stalled.

## Test plan

- **Reset mid-operation:** load to x5, then a dependent held in ID (stalled); assert `i_reset` mid-stall → `o_stall` drops the same cycle and all counters clear. After reset deasserts, the first valid instruction reading x5 issues with no stall.
- **ALU RAW:** issue `add x5` at t, then `sub` reading x5 in ID from t+1 → `o_stall`=1 for t+1..t+3 with `o_stall_load`=0, `sub` issues at t+4, and `o_stall_cnt`=3.
- **Load-use:** issue `lw x7` (defaults), then a dependent on rs2=x7 → 4 stall cycles, `o_stall_load`=1 throughout, and `o_stall_cnt` increases by 4.
- **Distance and x0:**
  - writer to x6; an unrelated instruction at t+1; a reader of x6 at t+2 → 2 stall cycles.
  - A reader of x0 after a write to x0 → 0 stall cycles.
- **WAW override:**
  - `lw x3` at t; an independent filler instruction (no x3 read) issues at t+1 and another at t+2.
  - `add x3` issues at t+3 and reloads `cnt[x3]` to 3, clearing `ld[x3]`.
  - A reader of x3 at t+4 stalls 3 cycles with `o_stall_load`=0.
- **Flush and saturation:**
  - A flushed ID instruction that would stall → `o_stall`=0 and no counter update.
  - With `STALL_CNT_W`=4, 20 stall cycles → `o_stall_cnt` holds at 15.
